// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile_sb register file.
package regfile_pkg;

    typedef enum logic {INIT, RUN} rf_state_e;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;

    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write vector: clear-all beats set, set beats release.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned AW       = rf_aw(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clrAll,
    input  logic          setEn,
    input  logic [AW-1:0] setAddr,
    input  logic          clrEn,
    input  logic [AW-1:0] clrAddr,
    input  logic [AW-1:0] rdAddr1,
    input  logic [AW-1:0] rdAddr2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pendingNext;

    always_comb begin
        pendingNext = pending;
        if (clrEn)
            pendingNext[clrAddr] = 1'b0;
        if (setEn)
            pendingNext[setAddr] = 1'b1;
        if (ZERO_REG)
            pendingNext[0] = 1'b0;
        if (clrAll)
            pendingNext = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pending <= '0;
        else
            pending <= pendingNext;
    end

    assign busy1 = pending[rdAddr1];
    assign busy2 = pending[rdAddr2];

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W register file with clear sweep and pending-write scoreboard.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = rf_aw(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clr_req,
    output logic            ready,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    rf_state_e       state, stateNext;
    logic [AW-1:0]   counter, counterNext;
    logic [XLEN-1:0] regs [NREGS];

    logic running, wrGate, rsvGate, clrAll;
    logic sbBusy1, sbBusy2, isZero1, isZero2;

    assign running = (state == RUN);
    assign wrGate  = running && wr_en;
    assign rsvGate = running && rsv_en;
    assign clrAll  = (state == INIT) || clr_req;
    assign ready   = running;
    assign isZero1 = ZERO_REG && (rd_addr1 == '0);
    assign isZero2 = ZERO_REG && (rd_addr2 == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            counter <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        case (state)
            INIT: begin
                counterNext = counter + 1'b1;
                if (counter == AW'(NREGS - 1)) begin
                    stateNext   = RUN;
                    counterNext = '0;
                end
            end
            RUN: begin
                if (clr_req) begin
                    stateNext   = INIT;
                    counterNext = '0;
                end
            end
            default: begin
                stateNext   = INIT;
                counterNext = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep is the only initialisation.
    always_ff @(posedge clock) begin
        if (state == INIT)
            regs[counter] <= '0;
        else if (wrGate && !(ZERO_REG && wr_addr == '0))
            regs[wr_addr] <= wr_data;
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) uScoreboard (
        .clock   (clock),
        .reset_n (reset_n),
        .clrAll  (clrAll),
        .setEn   (rsvGate),
        .setAddr (rsv_addr),
        .clrEn   (wrGate),
        .clrAddr (wr_addr),
        .rdAddr1 (rd_addr1),
        .rdAddr2 (rd_addr2),
        .busy1   (sbBusy1),
        .busy2   (sbBusy2)
    );

    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (running) begin
            if (!isZero1)
                rd_data1 = regs[rd_addr1];
            rd_busy1 = sbBusy1;
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == rd_addr1 && !isZero1) begin
                rd_data1 = wr_data;
                rd_busy1 = rsv_en && (rsv_addr == rd_addr1);
            end
`endif
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (running) begin
            if (!isZero2)
                rd_data2 = regs[rd_addr2];
            rd_busy2 = sbBusy2;
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == rd_addr2 && !isZero2) begin
                rd_data2 = wr_data;
                rd_busy2 = rsv_en && (rsv_addr == rd_addr2);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (XLEN=64, NREGS=32, ZERO_REG=1).
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clr_req;
    logic        ready;
    logic [4:0]  rd_addr1, rd_addr2, rsv_addr, wr_addr;
    logic [63:0] rd_data1, rd_data2, wr_data;
    logic        rd_busy1, rd_busy2;
    logic        rsv_en, wr_en;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    regfile_sb #(
        .XLEN     (64),
        .NREGS    (32),
        .ZERO_REG (1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic waitReady(input string tag, input int expCycles);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(expCycles));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        clr_req  = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tick();
        tick();
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_data1", rd_data1, 64'd0);
        check("reset_busy1", 64'(rd_busy1), 64'd0);

        reset_n = 1'b1;
        waitReady("init_sweep_len", 32);

        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            check("swept_data1", rd_data1, 64'd0);
            check("swept_busy2", 64'(rd_busy2), 64'd0);
        end

        // plain write then read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd5;
        #1;
        check("r5_data", rd_data1, 64'hDEAD_BEEF_0000_0001);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h1234;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd0;
        #1;
        check("r0_hardwired", rd_data1, 64'd0);

        // reservation lifecycle on r7
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        rsv_en = 1'b0; rd_addr1 = 5'd7;
        #1;
        check("r7_busy_set", 64'(rd_busy1), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
        tick();
        wr_en = 1'b0;
        #1;
        check("r7_busy_rel", 64'(rd_busy1), 64'd0);
        check("r7_data55", rd_data1, 64'h55);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h66;
        tick();
        rsv_en = 1'b0; wr_en = 1'b0;
        #1;
        check("r7_rsv_wins", 64'(rd_busy1), 64'd1);
        check("r7_data66", rd_data1, 64'h66);

        // r0 reservation is ignored
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0; rd_addr1 = 5'd0;
        #1;
        check("r0_never_busy", 64'(rd_busy1), 64'd0);

        // forwarding behaviour on r9 (reserved, old value 0x11)
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h11;
        tick();
        wr_en = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0; rd_addr2 = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAA;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r9_fwd_data", rd_data2, 64'hAA);
        check("r9_fwd_busy", 64'(rd_busy2), 64'd0);
`else
        check("r9_old_data", rd_data2, 64'h11);
        check("r9_old_busy", 64'(rd_busy2), 64'd1);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("r9_after_data", rd_data2, 64'hAA);
        check("r9_after_busy", 64'(rd_busy2), 64'd0);

        // clear sweep wipes data and reservations; writes during sweep dropped
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
        tick();
        wr_en = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd6;
        #1;
        check("r3_pre_data", rd_data1, 64'h77);
        check("r3_pre_busy", 64'(rd_busy1), 64'd1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_ready_low", 64'(ready), 64'd0);
        check("init_data_zero", rd_data1, 64'd0);
        check("init_busy_zero", 64'(rd_busy1), 64'd0);
        n = 0;
        while (!ready && n < 100) begin
            if (n == 20) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h99;
                rsv_en = 1'b1; rsv_addr = 5'd6;
            end else begin
                wr_en = 1'b0;
                rsv_en = 1'b0;
            end
            tick();
            n++;
        end
        wr_en = 1'b0; rsv_en = 1'b0;
        check("clr_sweep_len", 64'(n), 64'd32);
        #1;
        check("r3_post_data", rd_data1, 64'd0);
        check("r3_post_busy", 64'(rd_busy1), 64'd0);
        check("r6_no_rsv", 64'(rd_busy2), 64'd0);
        rd_addr1 = 5'd4;
        #1;
        check("r4_no_write", rd_data1, 64'd0);

        // reset mid-sweep restarts the sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        check("midsweep_rst_ready", 64'(ready), 64'd0);
        tick();
        reset_n = 1'b1;
        waitReady("restart_sweep_len", 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
